// File: rtl/chacha_qr_host_if.sv
// ---------------------------------------------------------------------------
// chacha_qr_host_if
//
// Purpose : groups the job handshake and the byte-wide peripheral bus of the
//           ChaCha quarter-round host into one bundle.
//
// Signals :
//   job input   in_valid, in_ready, in_state[127:0], in_steps[STEP_W-1:0]
//   job output  out_valid, out_ready, out_state[127:0]
//   status      busy
//   bus         bus_wdata[7:0], bus_rdata[7:0], bus_addr[3:0],
//               bus_wr_en, bus_qr_en, bus_er_sel
//
// Modports:
//   slave  - the host itself (accepts jobs, drives the peripheral bus)
//   master - the surroundings (issues jobs, consumes results, returns
//            peripheral read data)
// ---------------------------------------------------------------------------
interface chacha_qr_host_if #(
    parameter int STEP_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [127:0]      in_state;
    logic [STEP_W-1:0] in_steps;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      out_state;
    logic              busy;
    logic [7:0]        bus_wdata;
    logic [7:0]        bus_rdata;
    logic [3:0]        bus_addr;
    logic              bus_wr_en;
    logic              bus_qr_en;
    logic              bus_er_sel;

    modport slave (
        input  in_valid, in_state, in_steps, out_ready, bus_rdata,
        output in_ready, out_valid, out_state, busy,
               bus_wdata, bus_addr, bus_wr_en, bus_qr_en, bus_er_sel
    );

    modport master (
        output in_valid, in_state, in_steps, out_ready, bus_rdata,
        input  in_ready, out_valid, out_state, busy,
               bus_wdata, bus_addr, bus_wr_en, bus_qr_en, bus_er_sel
    );
endinterface

// File: rtl/chacha_qr_host.sv
// ---------------------------------------------------------------------------
// chacha_qr_host
//
// Purpose : host-side initiator for the byte-wide ChaCha quarter-round
//           peripheral. A job (128-bit state + step count) is written to the
//           peripheral byte by byte, the round-step strobe is pulsed the
//           requested number of times with alternating half-round select,
//           and the 16 result bytes are read back and presented on the
//           output handshake.
//
// Ports   :
//   clk    clock
//   rst_n  synchronous active-low reset (aborts any job, no result emitted)
//   hif    chacha_qr_host_if.slave: job in/out handshakes, busy, and the
//          peripheral bus (wdata, rdata, addr, wr_en, qr_en, er_sel)
//
// Parameters:
//   STEP_W    width of the step count (max 2**STEP_W-1 steps per job)
//   INIT_SEL  bus_er_sel value on the first step of every job
//
// Build option:
//   CHACHA_HOST_CLEAR_EN  when defined, 16 zero-writes scrub the peripheral
//                         registers after the read-back, before DONE.
//
// State a=[31:0], b=[63:32], c=[95:64], d=[127:96]; bus address [3:2] picks
// the word, [1:0] the byte lane, so byte index i lives at bits [8i+7:8i].
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module chacha_qr_host #(
    parameter int STEP_W   = 8,
    parameter bit INIT_SEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chacha_qr_host_if.slave       hif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_READ,
`ifdef CHACHA_HOST_CLEAR_EN
        ST_CLEAR,
`endif
        ST_DONE
    } state_t;

    // Everything that reaches a port, plus the FSM state and step counter.
    typedef struct packed {
        state_t            state;
        logic              in_ready;
        logic              busy;
        logic              out_valid;
        logic [127:0]      out_state;
        logic [STEP_W-1:0] cnt;
        logic [7:0]        wdata;
        logic [3:0]        addr;
        logic              wr_en;
        logic              qr_en;
        logic              er_sel;
    } regs_t;

    regs_t        r;
    regs_t        nx;
    logic [127:0] job_state;
    logic [3:0]   addr_inc;

    // NOTE: job_state is a pure data holding register; it is only ever read
    // after being loaded on job acceptance, so it carries no reset.
    always_ff @(posedge clk) begin
        if (r.in_ready && hif.in_valid) begin
            job_state <= hif.in_state;
        end
    end

    // NOTE: state registers update with non-blocking assignments so every
    // process samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r          <= '0;
            r.state    <= ST_IDLE;
            r.in_ready <= 1'b1;
        end else begin
            r <= nx;
        end
    end

    // NOTE: every field of nx gets a value before the case statement, so no
    // path through the logic can leave a latch behind.
    always_comb begin
        nx       = r;
        nx.wr_en = 1'b0;
        nx.qr_en = 1'b0;
        nx.wdata = 8'h00;
        addr_inc = r.addr + 4'd1;

        case (r.state)
            ST_IDLE: begin
                if (hif.in_valid) begin
                    nx.state    = ST_LOAD;
                    nx.in_ready = 1'b0;
                    nx.busy     = 1'b1;
                    nx.cnt      = hif.in_steps;
                    nx.er_sel   = INIT_SEL;
                    nx.addr     = 4'd0;
                    nx.wr_en    = 1'b1;
                    nx.wdata    = hif.in_state[7:0];
                end
            end

            ST_LOAD: begin
                if (r.addr == 4'd15) begin
                    nx.addr = 4'd0;
                    if (r.cnt == '0) begin
                        nx.state = ST_READ;
                    end else begin
                        nx.state  = ST_RUN;
                        nx.qr_en  = 1'b1;
                        nx.er_sel = INIT_SEL;
                        nx.cnt    = r.cnt - STEP_W'(1);
                    end
                end else begin
                    nx.addr  = addr_inc;
                    nx.wr_en = 1'b1;
                    nx.wdata = job_state[{addr_inc, 3'b000} +: 8];
                end
            end

            // cnt holds the steps still to issue after the current one, so it
            // reaches zero on the last step and never wraps.
            ST_RUN: begin
                if (r.cnt == '0) begin
                    nx.state = ST_READ;
                end else begin
                    nx.qr_en  = 1'b1;
                    nx.er_sel = ~r.er_sel;
                    nx.cnt    = r.cnt - STEP_W'(1);
                end
            end

            ST_READ: begin
                nx.out_state[{r.addr, 3'b000} +: 8] = hif.bus_rdata;
                if (r.addr == 4'd15) begin
                    nx.addr = 4'd0;
`ifdef CHACHA_HOST_CLEAR_EN
                    nx.state = ST_CLEAR;
                    nx.wr_en = 1'b1;
`else
                    nx.state     = ST_DONE;
                    nx.out_valid = 1'b1;
`endif
                end else begin
                    nx.addr = addr_inc;
                end
            end

`ifdef CHACHA_HOST_CLEAR_EN
            // wdata stays at its zero default: scrub every peripheral byte.
            ST_CLEAR: begin
                if (r.addr == 4'd15) begin
                    nx.addr      = 4'd0;
                    nx.state     = ST_DONE;
                    nx.out_valid = 1'b1;
                end else begin
                    nx.addr  = addr_inc;
                    nx.wr_en = 1'b1;
                end
            end
`endif

            ST_DONE: begin
                if (hif.out_ready) begin
                    nx.state     = ST_IDLE;
                    nx.out_valid = 1'b0;
                    nx.in_ready  = 1'b1;
                    nx.busy      = 1'b0;
                end
            end

            default: begin
                nx.state     = ST_IDLE;
                nx.in_ready  = 1'b1;
                nx.busy      = 1'b0;
                nx.out_valid = 1'b0;
                nx.addr      = 4'd0;
            end
        endcase
    end

    assign hif.in_ready   = r.in_ready;
    assign hif.busy       = r.busy;
    assign hif.out_valid  = r.out_valid;
    assign hif.out_state  = r.out_state;
    assign hif.bus_wdata  = r.wdata;
    assign hif.bus_addr   = r.addr;
    assign hif.bus_wr_en  = r.wr_en;
    assign hif.bus_qr_en  = r.qr_en;
    assign hif.bus_er_sel = r.er_sel;

endmodule

// File: tb/tb_chacha_qr_host.sv
// ---------------------------------------------------------------------------
// tb_chacha_qr_host
//
// Drives chacha_qr_host against a behavioural byte-wide quarter-round
// peripheral. Cycle numbers count from the job acceptance edge: cycle 1 is
// the period right after it. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_chacha_qr_host;

`ifdef CHACHA_HOST_CLEAR_EN
    localparam int EXTRA = 16;
`else
    localparam int EXTRA = 0;
`endif

    localparam logic [127:0] RFC_IN  = 128'h01234567_9b8d6f43_01020304_11111111;
    localparam logic [127:0] RFC_OUT = 128'h5881c4bb_4581472e_cb1cf8ce_ea2a92f4;

    logic clk = 1'b0;
    logic rst_n;

    chacha_qr_host_if #(.STEP_W(8)) hif ();

    chacha_qr_host #(.STEP_W(8), .INIT_SEL(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural peripheral ----------------
    logic [127:0] pmem;

    function automatic logic [127:0] half_round(input logic [127:0] s, input logic sel);
        logic [31:0] a, b, c, d;
        a = s[31:0];
        b = s[63:32];
        c = s[95:64];
        d = s[127:96];
        a = a + b;
        d = d ^ a;
        d = sel ? {d[23:0], d[31:24]} : {d[15:0], d[31:16]};
        c = c + d;
        b = b ^ c;
        b = sel ? {b[24:0], b[31:25]} : {b[19:0], b[31:20]};
        return {d, c, b, a};
    endfunction

    always @(posedge clk) begin
        if (hif.bus_wr_en) begin
            pmem[{hif.bus_addr, 3'b000} +: 8] <= hif.bus_wdata;
        end else if (hif.bus_qr_en) begin
            pmem <= half_round(pmem, hif.bus_er_sel);
        end
    end

    assign hif.bus_rdata = pmem[{hif.bus_addr, 3'b000} +: 8];

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [127:0] st, input logic [7:0] n);
        int w;
        w = 0;
        @(negedge clk);
        while (!hif.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("start_in_ready", 128'(hif.in_ready), 128'd1);
        hif.in_valid = 1'b1;
        hif.in_state = st;
        hif.in_steps = n;
        @(posedge clk);
        @(negedge clk);
        hif.in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [127:0] st, input logic [7:0] n,
                           input int hold, input bit poke,
                           output logic [127:0] res, output int vcyc,
                           output int qrn, output logic [1:0] sels,
                           output logic last_sel);
        int cyc;
        bit both;
        start_job(st, n);
        cyc      = 1;
        qrn      = 0;
        sels     = 2'b00;
        vcyc     = -1;
        both     = 1'b0;
        last_sel = 1'b0;
        while (cyc < 2000) begin
            if (cyc == 1) begin
                check("load_first_wr", {hif.bus_wr_en, hif.bus_addr, hif.bus_wdata},
                      {1'b1, 4'd0, st[7:0]});
            end
            if (cyc == 16) begin
                check("load_last_wr", {hif.bus_wr_en, hif.bus_addr, hif.bus_wdata},
                      {1'b1, 4'd15, st[127:120]});
            end
            if (hif.bus_qr_en) begin
                if (qrn < 2) sels[qrn] = hif.bus_er_sel;
                last_sel = hif.bus_er_sel;
                qrn++;
            end
            if (hif.bus_qr_en && hif.bus_wr_en) both = 1'b1;
            if (poke && cyc == 5) begin
                check("busy_in_ready", {hif.busy, hif.in_ready}, 2'b10);
                hif.in_valid = 1'b1;
                hif.in_state = ~st;
                hif.in_steps = 8'd3;
            end else if (poke && cyc == 6) begin
                hif.in_valid = 1'b0;
            end
            if (hif.out_valid) begin
                vcyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("out_valid_seen", 128'(vcyc != -1), 128'd1);
        check("strobes_exclusive", 128'(both), 128'd0);
        res = hif.out_state;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_state", hif.out_state, res);
            check("hold_flags", {hif.out_valid, hif.in_ready}, 2'b10);
        end
        hif.out_ready = 1'b1;
        @(negedge clk);
        hif.out_ready = 1'b0;
        check("after_hs_flags", {hif.out_valid, hif.in_ready, hif.busy}, 3'b010);
        check("after_hs_state", hif.out_state, res);
        @(negedge clk);
        check("no_second_job", {hif.bus_wr_en, hif.busy}, 2'b00);
    endtask

    typedef struct {
        logic [127:0] st;
        logic [7:0]   n;
        logic [127:0] exp;
        int           hold;
        bit           poke;
    } vec_t;

    vec_t         vecs[3];
    logic [127:0] res;
    int           vcyc;
    int           qrn;
    logic [1:0]   sels;
    logic         last_sel;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{st: RFC_IN, n: 8'd2, exp: RFC_OUT, hold: 0, poke: 1'b0};
        vecs[1] = '{st: 128'h00112233_44556677_8899aabb_ccddeeff, n: 8'd0,
                    exp: 128'h00112233_44556677_8899aabb_ccddeeff, hold: 0, poke: 1'b0};
        vecs[2] = '{st: RFC_IN, n: 8'd2, exp: RFC_OUT, hold: 10, poke: 1'b1};

        hif.in_valid  = 1'b0;
        hif.in_state  = '0;
        hif.in_steps  = '0;
        hif.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {hif.in_ready, hif.busy, hif.out_valid}, 3'b100);
        check("reset_out_state", hif.out_state, '0);
        check("reset_bus", {hif.bus_wdata, hif.bus_addr, hif.bus_wr_en, hif.bus_qr_en, hif.bus_er_sel}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run_job(vecs[i].st, vecs[i].n, vecs[i].hold, vecs[i].poke, res, vcyc, qrn, sels, last_sel);
            check("vec_result", res, vecs[i].exp);
            check("vec_valid_cycle", 128'(vcyc), 128'(33 + int'(vecs[i].n) + EXTRA));
            check("vec_qr_count", 128'(qrn), 128'(vecs[i].n));
            if (vecs[i].n == 8'd2) begin
                check("vec_er_sel_seq", 128'(sels), 128'(2'b10));
            end
`ifdef CHACHA_HOST_CLEAR_EN
            check("clear_scrubbed", pmem, '0);
`endif
        end

        // Reset during RUN cycle 18 of a 20-step job.
        start_job(RFC_IN, 8'd20);
        repeat (17) @(negedge clk);
        check("mid_run_qr", 128'(hif.bus_qr_en), 128'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_bus", {hif.bus_wdata, hif.bus_addr, hif.bus_wr_en, hif.bus_qr_en, hif.bus_er_sel}, '0);
        check("abort_flags", {hif.in_ready, hif.busy, hif.out_valid}, 3'b100);
        rst_n = 1'b1;
        run_job(RFC_IN, 8'd2, 0, 1'b0, res, vcyc, qrn, sels, last_sel);
        check("post_abort_result", res, RFC_OUT);
        check("post_abort_cycle", 128'(vcyc), 128'(35 + EXTRA));

        // Maximum step count.
        run_job(RFC_IN, 8'd255, 0, 1'b0, res, vcyc, qrn, sels, last_sel);
        check("max_qr_count", 128'(qrn), 128'd255);
        check("max_last_sel", 128'(last_sel), 128'd0);
        check("max_valid_cycle", 128'(vcyc), 128'(288 + EXTRA));
        check("max_sel_after", 128'(hif.bus_er_sel), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
